// File: rtl/snn_pkg.sv
// snn_pkg: shared sizes, controller state type and threshold helper for the SNN inference controller
package snn_pkg;
   localparam int N               = 256;
   localparam int M               = $clog2(N);
   localparam int IMAGE_SIZE      = 256;
   localparam int PIXEL_BITS      = 8;
   localparam int PIXEL_MAX_VALUE = 255;
   localparam int TIMESTEPS       = 8;
   localparam int THR_STEP        = 32;
   localparam int NUM_CLASSES     = 10;
   localparam int CNT_BITS        = 8;
   localparam int TW              = $clog2(TIMESTEPS);
   localparam int CW              = $clog2(NUM_CLASSES);
   localparam int DW              = PIXEL_BITS + TW + 1;

   typedef enum logic [2:0] {IDLE, CLEAR, SCAN, EMIT, TICK, ARGMAX, FINISH} ctrl_state_e;

   // Latency-coding threshold; a negative difference wraps above the max value and saturates to 0
   function automatic logic [PIXEL_BITS-1:0] thr_at(input logic [TW-1:0] t);
      logic [DW-1:0] d;
      d = DW'(PIXEL_MAX_VALUE) - DW'(t) * DW'(THR_STEP);
      return (d > DW'(PIXEL_MAX_VALUE)) ? '0 : d[PIXEL_BITS-1:0];
   endfunction
endpackage

// File: rtl/snn_inference_controller_if.sv
// snn_inference_controller_if: image source, core handshakes and result signals of the controller
interface snn_inference_controller_if;
   import snn_pkg::*;
   logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] image;
   logic                                  new_image;
   logic                                  snn_clear;
   logic [M-1:0]                          aer_addr;
   logic                                  aer_req;
   logic                                  aer_ack;
   logic                                  tick_req;
   logic                                  tick_ack;
   logic                                  out_spike_valid;
   logic [M-1:0]                          out_spike_id;
   logic [M-1:0]                          infered_digit;
   logic                                  busy;
   logic                                  done;

   modport master (
      input  image, new_image, aer_ack, tick_ack, out_spike_valid, out_spike_id,
      output snn_clear, aer_addr, aer_req, tick_req, infered_digit, busy, done
   );
   modport slave (
      output image, new_image, aer_ack, tick_ack, out_spike_valid, out_spike_id,
      input  snn_clear, aer_addr, aer_req, tick_req, infered_digit, busy, done
   );
endinterface

// File: rtl/snn_class_counter.sv
// snn_class_counter: per-class saturating spike counters and a one-class-per-cycle argmax
module snn_class_counter
   import snn_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         cnt_en_i,
   input  logic         spike_valid_i,
   input  logic [M-1:0] spike_id_i,
   input  logic         arg_i,
   output logic [M-1:0] winner_o,
   output logic         done_o
);
   logic [CNT_BITS-1:0] cnt_q [NUM_CLASSES];
   logic [CNT_BITS-1:0] best_q;
   logic [CW-1:0]       idx_q;
   logic [M-1:0]        win_q;

   // Saturating counters; ids at or above NUM_CLASSES match no counter and are dropped
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         for (int k = 0; k < NUM_CLASSES; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CLASSES; k++)
            if (cnt_en_i && spike_valid_i && spike_id_i == M'(k) && cnt_q[k] != '1)
               cnt_q[k] <= cnt_q[k] + CNT_BITS'(1);
      end
   end

   // Sequential argmax; strict compare keeps the lowest index on ties and 0 when all are empty
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         idx_q  <= '0;
         best_q <= '0;
         win_q  <= '0;
      end else if (arg_i) begin
         idx_q <= idx_q + CW'(1);
         if (cnt_q[idx_q] > best_q) begin
            best_q <= cnt_q[idx_q];
            win_q  <= M'(idx_q);
         end
      end
   end

   assign winner_o = win_q;
   assign done_o   = arg_i && idx_q == CW'(NUM_CLASSES - 1);
endmodule

// File: rtl/snn_inference_controller.sv
// snn_inference_controller: clears the core, latency-encodes the image into AER spikes over TIMESTEPS ticks, and reports the argmax class
module snn_inference_controller
   import snn_pkg::*;
(
   input logic                        clk_i,
   input logic                        rst_i,
   snn_inference_controller_if.master bus
);
   ctrl_state_e           state_q, state_d;
   logic [M-1:0]          px_q;
   logic [TW-1:0]         t_q;
   logic [IMAGE_SIZE-1:0] spiked_q;
   logic                  nl_q;
   logic [M-1:0]          digit_q;
   logic [PIXEL_BITS-1:0] pix;
   logic                  start, fire, last_px, last_t, cls_done;
   logic [M-1:0]          winner;

   assign start   = bus.new_image && !nl_q && state_q == IDLE;
   assign pix     = bus.image[px_q];
   assign fire    = pix != '0 && pix >= thr_at(t_q) && !spiked_q[px_q];
   assign last_px = px_q == M'(IMAGE_SIZE - 1);
   assign last_t  = t_q == TW'(TIMESTEPS - 1);

   // State register
   always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = SCAN;
         SCAN:    state_d = fire ? EMIT : last_px ? TICK : SCAN;
         EMIT:    if (bus.aer_ack) state_d = last_px ? TICK : SCAN;
         TICK:    if (bus.tick_ack) state_d = last_t ? ARGMAX : SCAN;
         ARGMAX:  if (cls_done) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the registered state; the result is visible already during the DONE cycle
   always_comb begin
      bus.snn_clear     = state_q == CLEAR;
      bus.aer_req       = state_q == EMIT;
      bus.aer_addr      = state_q == EMIT ? px_q : '0;
      bus.tick_req      = state_q == TICK;
      bus.busy          = state_q != IDLE;
      bus.done          = state_q == FINISH;
      bus.infered_digit = state_q == FINISH ? winner : digit_q;
   end

   // Start edge detector, pixel and time-step counters, fired-pixel bitmap and held result
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         nl_q     <= 1'b0;
         px_q     <= '0;
         t_q      <= '0;
         spiked_q <= '0;
         digit_q  <= '0;
      end else begin
         nl_q <= bus.new_image;
         if (start) begin
            px_q     <= '0;
            t_q      <= '0;
            spiked_q <= '0;
            digit_q  <= '0;
         end
         if (state_q == SCAN) begin
            if (fire) spiked_q[px_q] <= 1'b1;
            else px_q <= px_q + M'(1);
         end
         if (state_q == EMIT && bus.aer_ack) px_q <= px_q + M'(1);
         if (state_q == TICK && bus.tick_ack) begin
            px_q <= '0;
            if (!last_t) t_q <= t_q + TW'(1);
         end
         if (state_q == FINISH) digit_q <= winner;
      end
   end

   snn_class_counter u_cnt (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clr_i         (start),
      .cnt_en_i      (state_q inside {SCAN, EMIT, TICK}),
      .spike_valid_i (bus.out_spike_valid),
      .spike_id_i    (bus.out_spike_id),
      .arg_i         (state_q == ARGMAX),
      .winner_o      (winner),
      .done_o        (cls_done)
   );
endmodule

// File: tb/tb_snn_inference_controller.sv
// tb_snn_inference_controller: scoreboard bench comparing observed clear/AER/tick/done events against a latency-coding reference model
module tb_snn_inference_controller;
   import snn_pkg::*;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] val;
      logic [3:0] step;
   } ev_t;

   localparam logic [1:0] K_CLR = 2'd0, K_AER = 2'd1, K_TICK = 2'd2, K_DONE = 2'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   aer_delay = 0;
   int   tick_delay = 0;
   int   cyc;
   ev_t  exp_q[$];
   int   spk_q[$];
   int   sp[$];
   logic [PIXEL_BITS-1:0] img [IMAGE_SIZE];

   snn_inference_controller_if bus ();

   snn_inference_controller dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   function automatic ev_t mk(input logic [1:0] k, input int v, input int s);
      ev_t e;
      e.kind = k;
      e.val  = 8'(v);
      e.step = 4'(s);
      return e;
   endfunction

   function automatic logic [31:0] outs();
      return 32'({bus.snn_clear, bus.aer_req, bus.aer_addr, bus.tick_req, bus.infered_digit, bus.busy, bus.done});
   endfunction

   task automatic got(input ev_t e);
      ev_t w;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event: got kind=%0d val=%0d step=%0d, expected no event", e.kind, e.val, e.step);
      end else begin
         w = exp_q.pop_front();
         if (e !== w) begin
            n_fail++;
            $display("FAIL event: got kind=%0d val=%0d step=%0d, expected kind=%0d val=%0d step=%0d",
                     e.kind, e.val, e.step, w.kind, w.val, w.step);
         end
      end
   endtask

   // Reference model: threshold falls by THR_STEP per step; every nonzero pixel fires once, in the first step where it reaches the threshold
   task automatic expect_run();
      int cnt [NUM_CLASSES];
      bit fired [IMAGE_SIZE];
      int thr, best;
      foreach (cnt[i]) cnt[i] = 0;
      foreach (fired[i]) fired[i] = 1'b0;
      exp_q.push_back(mk(K_CLR, 0, 0));
      for (int t = 0; t < TIMESTEPS; t++) begin
         thr = PIXEL_MAX_VALUE - t * THR_STEP;
         if (thr < 0) thr = 0;
         for (int p = 0; p < IMAGE_SIZE; p++)
            if (img[p] != 0 && int'(img[p]) >= thr && !fired[p]) begin
               fired[p] = 1'b1;
               exp_q.push_back(mk(K_AER, p, t));
            end
         exp_q.push_back(mk(K_TICK, 0, t));
      end
      foreach (sp[i]) if (sp[i] < NUM_CLASSES && cnt[sp[i]] < (1 << CNT_BITS) - 1) cnt[sp[i]]++;
      best = 0;
      for (int c = 1; c < NUM_CLASSES; c++) if (cnt[c] > cnt[best]) best = c;
      exp_q.push_back(mk(K_DONE, best, 0));
      foreach (sp[i]) spk_q.push_back(sp[i]);
   endtask

   task automatic clear_img();
      foreach (img[i]) img[i] = '0;
   endtask

   task automatic apply_img();
      for (int i = 0; i < IMAGE_SIZE; i++) bus.image[i] = img[i];
   endtask

   task automatic run(input bit toggle, input bit hold, output int n);
      apply_img();
      expect_run();
      @(posedge clk); #1 bus.new_image = 1'b0;
      @(posedge clk); #1 bus.new_image = 1'b1;
      n = 0;
      if (toggle) begin
         repeat (20) begin @(negedge clk); n++; end
         @(posedge clk); #1 bus.new_image = 1'b0;
         @(posedge clk); #1 bus.new_image = 1'b1;
         @(posedge clk); #1 bus.new_image = 1'b0;
         @(posedge clk); #1 bus.new_image = 1'b1;
      end
      do begin @(negedge clk); n++; end while (!bus.done && n < 20000);
      if (!bus.done) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: got no DONE after %0d cycles, expected DONE", n);
      end
      if (hold) begin
         repeat (20) @(negedge clk);
         chk("no_restart_busy", 32'(bus.busy), 0);
      end else begin
         @(posedge clk); #1 bus.new_image = 1'b0;
         repeat (2) @(negedge clk);
      end
      chk("busy_after_done", 32'(bus.busy), 0);
      chk("events_drained", exp_q.size(), 0);
      chk("spikes_consumed", spk_q.size(), 0);
   endtask

   // AER sink: holds ACK low aer_delay cycles after REQ rises, then accepts
   initial begin
      int wc;
      wc = 0;
      bus.aer_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!bus.aer_req) begin bus.aer_ack = 1'b0; wc = aer_delay; end
         else if (wc > 0) begin bus.aer_ack = 1'b0; wc--; end
         else bus.aer_ack = 1'b1;
      end
   end

   // Core model: answers ticks after tick_delay cycles and emits one queued output spike per cycle while a tick is pending
   initial begin
      int wc;
      wc = 0;
      bus.tick_ack = 1'b0;
      bus.out_spike_valid = 1'b0;
      bus.out_spike_id = '0;
      forever begin
         @(posedge clk); #1;
         if (!bus.tick_req) begin bus.tick_ack = 1'b0; wc = tick_delay; end
         else if (wc > 0) begin bus.tick_ack = 1'b0; wc--; end
         else bus.tick_ack = 1'b1;
         if (bus.tick_req && spk_q.size() > 0) begin
            bus.out_spike_valid = 1'b1;
            bus.out_spike_id = 8'(spk_q.pop_front());
         end else begin
            bus.out_spike_valid = 1'b0;
            bus.out_spike_id = '0;
         end
      end
   end

   // Monitor: turns DUT handshakes into events for the scoreboard and checks request stability under backpressure
   initial begin
      int step, aer_len;
      logic aer_pend, tick_pend;
      logic [M-1:0] aer_prev;
      step = 0; aer_len = 0; aer_pend = 1'b0; tick_pend = 1'b0; aer_prev = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            step = 0; aer_len = 0; aer_pend = 1'b0; tick_pend = 1'b0;
         end else begin
            if (aer_pend) chk("aer_req_addr_hold", 32'({bus.aer_req, bus.aer_addr}), 32'({1'b1, aer_prev}));
            if (tick_pend) chk("tick_req_hold", 32'(bus.tick_req), 1);
            if (bus.snn_clear) begin step = 0; got(mk(K_CLR, int'(bus.infered_digit), 0)); end
            if (bus.aer_req) aer_len++;
            if (bus.aer_req && bus.aer_ack) begin
               got(mk(K_AER, int'(bus.aer_addr), step));
               chk("aer_req_cycles", aer_len, aer_delay + 1);
               aer_len = 0;
            end
            if (bus.tick_req && bus.tick_ack) begin got(mk(K_TICK, 0, step)); step++; end
            if (bus.done) got(mk(K_DONE, int'(bus.infered_digit), 0));
            aer_pend  = bus.aer_req && !bus.aer_ack;
            aer_prev  = bus.aer_addr;
            tick_pend = bus.tick_req && !bus.tick_ack;
         end
      end
   end

   initial begin
      bus.new_image = 1'b0;
      clear_img();
      apply_img();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", outs(), 0);

      // single bright pixel fires at step 0
      img[5] = 8'd255;
      sp.delete();
      run(1'b0, 1'b0, cyc);

      // latency coding plus argmax with ignored out-of-range id
      clear_img();
      img[17] = 8'd200; img[40] = 8'd31; img[41] = 8'd20;
      sp = '{7, 7, 7, 3, 3, 12};
      run(1'b0, 1'b0, cyc);

      // tie resolves to the lowest class
      clear_img();
      img[3] = 8'd100;
      sp = '{4, 4, 6, 6};
      run(1'b0, 1'b0, cyc);

      // backpressure on both handshakes, including a spike on the last pixel
      aer_delay = 5; tick_delay = 3;
      clear_img();
      img[0] = 8'd255; img[128] = 8'd130; img[255] = 8'd255;
      sp = '{1, 9, 9, 1, 9, 15};
      run(1'b0, 1'b0, cyc);
      aer_delay = 0; tick_delay = 0;

      // empty image gives the minimum latency and class 0
      clear_img();
      sp.delete();
      run(1'b0, 1'b0, cyc);
      chk("min_latency", cyc - 1, 1 + TIMESTEPS * (IMAGE_SIZE + 1) + NUM_CLASSES + 1);

      // retrigger while busy is ignored, held level after DONE does not restart
      clear_img();
      img[10] = 8'd255;
      sp = '{2, 2};
      run(1'b1, 1'b1, cyc);
      clear_img();
      img[11] = 8'd250;
      sp.delete();
      run(1'b0, 1'b0, cyc);

      // reset during the step-3 emission aborts without DONE
      clear_img();
      img[7] = 8'd255; img[100] = 8'd159;
      sp.delete();
      aer_delay = 5;
      apply_img();
      expect_run();
      @(posedge clk); #1 bus.new_image = 1'b0;
      @(posedge clk); #1 bus.new_image = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!(bus.aer_req && bus.aer_addr == 8'd100) && cyc < 5000);
      chk("emit_px100_seen", 32'(bus.aer_req && bus.aer_addr == 8'd100), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.new_image = 1'b0;
      exp_q.delete();
      spk_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_outputs", outs(), 0);
      repeat (30) @(negedge clk);
      chk("abort_stays_idle", 32'(bus.busy), 0);
      aer_delay = 0;
      run(1'b0, 1'b0, cyc);

      // randomized sparse images, spikes and handshake delays
      for (int r = 0; r < 6; r++) begin
         int np, ns;
         clear_img();
         np = int'($urandom_range(0, 8));
         for (int i = 0; i < np; i++) img[$urandom_range(0, IMAGE_SIZE - 1)] = 8'($urandom_range(1, 255));
         aer_delay = int'($urandom_range(0, 3));
         tick_delay = int'($urandom_range(0, 2));
         sp.delete();
         ns = int'($urandom_range(0, TIMESTEPS * (tick_delay + 1)));
         for (int i = 0; i < ns; i++) sp.push_back(int'($urandom_range(0, 15)));
         run(1'b0, 1'b0, cyc);
      end
      aer_delay = 0;
      tick_delay = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/snn_inference_controller.md
Name: snn_inference_controller

Overview:
- Sequences one inference of the SNN core.
- On a new image from the AXI4-Lite slave, it clears the core and latency-encodes the pixels into AER input spikes over TIMESTEPS time steps, advancing core time with a tick handshake.
- It counts output-neuron spikes per class, resolves the argmax, and drives INFERED_DIGIT back to the slave's read register.

Parameters:
- N, 256, maximum neurons in core.
- M, 8, log2(N); AER address and INFERED_DIGIT width.
- IMAGE_SIZE, 256, pixel count; must be ≤ N.
- PIXEL_BITS, 8, pixel width.
- PIXEL_MAX_VALUE, 255, threshold at time step 0.
- TIMESTEPS, 8, time steps per inference.
- THR_STEP, 32, threshold decrement per time step.
- NUM_CLASSES, 10, number of output neurons counted.
- CNT_BITS, 8, per-class spike counter width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- IMAGE  in  PIXEL_BITS x IMAGE_SIZE  pixel array from the AXI slave.
- NEW_IMAGE  in  1  level flag; a rising edge starts an inference.
- SNN_CLEAR  out  1  one-cycle pulse that clears core membranes.
- AER_ADDR  out  M  input-spike neuron address.
- AER_REQ  out  1  spike valid.
- AER_ACK  in  1  spike accepted.
- TICK_REQ  out  1  request to advance core time step.
- TICK_ACK  in  1  time step completed.
- OUT_SPIKE_VALID  in  1  core output spike strobe.
- OUT_SPIKE_ID  in  M  output neuron index.
- INFERED_DIGIT  out  M  result.
- BUSY  out  1  inference in progress.
- DONE  out  1  one-cycle pulse when INFERED_DIGIT is valid.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is synchronous and active-high.
- Reset values: every output is 0; FSM is IDLE; counters, spiked bitmap and edge register are cleared.
- Reset mid-operation aborts immediately, with no DONE.
- Start detection: registered nl = NEW_IMAGE; start = NEW_IMAGE & ~nl & state==IDLE. Rising edges outside IDLE are ignored.
- State IDLE: on start, go to CLEAR. Clear INFERED_DIGIT, class counters and spiked bitmap; t=0, px=0.
- State CLEAR: SNN_CLEAR=1 for exactly one cycle, then SCAN. BUSY=1 in every state except IDLE.
- Threshold: thr = PIXEL_MAX_VALUE - t*THR_STEP, saturating at 0, with PIXEL_BITS+$clog2(TIMESTEPS)+1 bit intermediate.
- Fire condition: IMAGE[px]!=0 & IMAGE[px]>=thr & !spiked[px]. Each pixel fires at most once per inference.
- State SCAN: evaluates one pixel per cycle.
  - Fire: set spiked[px], AER_ADDR=px, go to EMIT.
  - No fire: px++.
  - px==IMAGE_SIZE-1 with no fire: go to TICK.
- State EMIT:
  - AER_REQ stays high and AER_ADDR stays stable until AER_ACK is sampled high.
  - On ACK: AER_REQ drops next cycle; return to SCAN with px++, or go to TICK if px was last.
  - AER_ACK in the same cycle AER_REQ rises is legal (transfer in 1 cycle).
- State TICK:
  - TICK_REQ held until TICK_ACK.
  - On ACK: px=0. If t==TIMESTEPS-1 go to ARGMAX, else t++ and go to SCAN.
- Counting: while in SCAN, EMIT or TICK, OUT_SPIKE_VALID with OUT_SPIKE_ID<NUM_CLASSES increments cnt[id], saturating at 2^CNT_BITS-1. Other IDs are ignored. Spikes outside these states are ignored.
- State ARGMAX:
  - Sequential scan, one class per cycle, NUM_CLASSES cycles.
  - Strict greater-than, so ties go to the lowest index; all-zero yields 0.
  - Then go to FINISH.
- State FINISH: latch INFERED_DIGIT, DONE=1 for one cycle, go to IDLE. INFERED_DIGIT is held until the next start.
- IMAGE is sampled live, not copied. Software must not write pixels while BUSY; this contract is not checked.
- Minimum latency with no spikes: 1 (CLEAR) + TIMESTEPS*(IMAGE_SIZE + tick latency) + NUM_CLASSES + 1 cycles.

Decomposition:
- Shared package snn_pkg holds:
  - the ctrl_state_e enum (IDLE, CLEAR, SCAN, EMIT, TICK, ARGMAX, FINISH);
  - localparams NUM_CLASSES, TIMESTEPS, THR_STEP;
  - a function thr_at(t) with saturating subtraction.
- One sub-module: snn_class_counter (per-class saturating counters plus the sequential argmax). Outputs winner and a done strobe.

Test Plan:
- Single pixel: reset; IMAGE all 0 except px5=255; raise NEW_IMAGE.
  - Expect SNN_CLEAR pulse, then AER event addr 5 at t=0, then exactly 8 TICK handshakes and no other AER events.
  - DONE once; BUSY low after.
- Latency coding: px17=200, px40=31, px41=20.
  - Expect px17 emitted in time step 2 (thr 191), px40 in time step 7 (thr 31), px41 never.
  - Expect 2 AER events total.
- Argmax: drive OUT_SPIKE_VALID 3x id 7, 2x id 3, 1x id 12 during run → INFERED_DIGIT=7. Equal counts 2x id 4 and 2x id 6 → INFERED_DIGIT=4.
- Backpressure: hold AER_ACK low 5 cycles, then TICK_ACK low 3 cycles.
  - Expect AER_REQ and AER_ADDR stable throughout, no lost or duplicated events.
  - Same-cycle ACK completes in 1 cycle.
- Retrigger: NEW_IMAGE toggled 0→1→0→1 while BUSY → ignored. After DONE, NEW_IMAGE still high → no restart. Fall then rise → new run; INFERED_DIGIT cleared to 0 at start.
- Reset mid-run: assert RST during EMIT of time step 3 → next cycle all outputs 0, state IDLE, no DONE. A subsequent run behaves identically to a fresh run.
